lcd_spi_sequencer: RTL and testbench

Sequences single-word serial transfers to the static-screen LCD panel inside the Wishbone static-screen peripheral. It accepts one word plus a data/command flag through a valid/ready handshake and generates the divided serial clock, chip select, data/command line and MSB-first MOSI stream. MOSI changes only on falling serial-clock edges, so the panel samples stable data on rising edges. It sits between the Wishbone register front end and the LCD Pmod pins, and replaces ad-hoc shift/extract logic with one controlled sequencer.

---
 rtl/lcd_spi_sequencer_if.sv | 12 +
 rtl/lcd_spi_sequencer.sv | 138 +++++++++++++
 tb/tb_lcd_spi_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_sequencer_if.sv
// rtl/lcd_spi_sequencer_if.sv - request handshake bundle for the LCD serial sequencer
interface lcd_spi_sequencer_if #(
  parameter int SIZE = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [SIZE-1:0] req_data;
  logic            req_dc;

  modport master (output req_valid, output req_data, output req_dc, input req_ready);
  modport slave  (input req_valid, input req_data, input req_dc, output req_ready);
endinterface

// File: rtl/lcd_spi_sequencer.sv
// rtl/lcd_spi_sequencer.sv - MSB-first LCD serial word sequencer (LCD_SPI_BURST_EN: back-to-back words)
module lcd_spi_sequencer #(
  parameter int SIZE    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_spi_sequencer_if.slave  req,
  output logic                sck,
  output logic                mosi,
  output logic                cs_n,
  output logic                dc,
  output logic                busy,
  output logic                done
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(SIZE + 1);
  localparam logic [HW-1:0] HP_LAST  = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(SIZE);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t          r_state;
  logic [HW-1:0]   r_hp;
  logic [BW-1:0]   r_bit;
  logic [SIZE-1:0] r_shift;
  logic            r_sck;
  logic            r_mosi;
  logic            r_cs_n;
  logic            r_dc;
  logic            r_done;
  logic            r_en;

  logic            w_hp_end;
  logic            w_burst_slot;
  logic            w_ready;
  logic            w_accept;

  assign w_hp_end = (r_hp == HP_LAST);

`ifdef LCD_SPI_BURST_EN
  assign w_burst_slot = (r_state == S_HOLD) && w_hp_end;
`else
  assign w_burst_slot = 1'b0;
`endif

  // r_en keeps req_ready low until the first edge after reset release
  assign w_ready       = r_en && ((r_state == S_IDLE) || w_burst_slot);
  assign w_accept      = req.req_valid && w_ready;
  assign req.req_ready = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hp    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_en   <= 1'b1;
      r_done <= 1'b0;
      if (w_accept) begin
        // a burst acceptance still closes the previous word with a done pulse
        r_done  <= (r_state == S_HOLD);
        r_state <= S_SETUP;
        r_hp    <= '0;
        r_bit   <= '0;
        r_sck   <= 1'b0;
        r_cs_n  <= 1'b0;
        r_dc    <= req.req_dc;
        r_shift <= req.req_data;
        r_mosi  <= req.req_data[SIZE-1];
      end else begin
        case (r_state)
          S_IDLE: begin
            r_hp  <= '0;
            r_sck <= 1'b0;
          end
          S_SETUP: begin
            if (w_hp_end) begin
              r_hp    <= '0;
              r_sck   <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_hp <= r_hp + HW'(1);
            end
          end
          S_SHIFT: begin
            if (w_hp_end) begin
              r_hp <= '0;
              if (r_sck) begin
                // falling edge: advance to the next bit unless this was the last one
                r_sck <= 1'b0;
                if (r_bit != BIT_LAST) begin
                  r_shift <= {r_shift[SIZE-2:0], 1'b0};
                  r_mosi  <= r_shift[SIZE-2];
                end
                if (r_bit != BIT_END) r_bit <= r_bit + BW'(1);
              end else if (r_bit == BIT_END) begin
                r_state <= S_HOLD;
              end else begin
                r_sck <= 1'b1;
              end
            end else begin
              r_hp <= r_hp + HW'(1);
            end
          end
          S_HOLD: begin
            if (w_hp_end) begin
              r_hp    <= '0;
              r_done  <= 1'b1;
              r_cs_n  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_hp <= r_hp + HW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sck  = r_sck;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;
  assign dc   = r_dc;
  assign done = r_done;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// tb/tb_lcd_spi_sequencer.sv - directed bench for lcd_spi_sequencer (default and CLK_DIV=1/SIZE=16)
module tb_lcd_spi_sequencer;

`ifdef LCD_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic v_sel, v_valid, v_dc;
  logic [15:0] v_data;
  int n_cmp, n_fail;

  logic a_sck, a_mosi, a_cs_n, a_dc, a_busy, a_done;
  logic b_sck, b_mosi, b_cs_n, b_dc, b_busy, b_done;

  logic s_sck [0:199];
  logic s_mosi[0:199];
  logic s_cs  [0:199];
  logic s_dc  [0:199];
  logic s_done[0:199];
  logic s_rdy [0:199];
  logic s_busy[0:199];

  lcd_spi_sequencer_if #(.SIZE(8))  if_a ();
  lcd_spi_sequencer_if #(.SIZE(16)) if_b ();

  assign if_a.req_valid = v_valid & ~v_sel;
  assign if_a.req_data  = v_data[7:0];
  assign if_a.req_dc    = v_dc;
  assign if_b.req_valid = v_valid & v_sel;
  assign if_b.req_data  = v_data;
  assign if_b.req_dc    = v_dc;

  lcd_spi_sequencer #(.SIZE(8), .CLK_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(if_a),
    .sck(a_sck), .mosi(a_mosi), .cs_n(a_cs_n), .dc(a_dc), .busy(a_busy), .done(a_done)
  );

  lcd_spi_sequencer #(.SIZE(16), .CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(if_b),
    .sck(b_sck), .mosi(b_mosi), .cs_n(b_cs_n), .dc(b_dc), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sample(input int e);
    if (v_sel) begin
      s_sck[e] = b_sck; s_mosi[e] = b_mosi; s_cs[e] = b_cs_n; s_dc[e] = b_dc;
      s_done[e] = b_done; s_rdy[e] = if_b.req_ready; s_busy[e] = b_busy;
    end else begin
      s_sck[e] = a_sck; s_mosi[e] = a_mosi; s_cs[e] = a_cs_n; s_dc[e] = a_dc;
      s_done[e] = a_done; s_rdy[e] = if_a.req_ready; s_busy[e] = a_busy;
    end
  endtask

  // Index e of the sample arrays holds outputs just after edge e, edge 0 being the acceptance edge.
  task automatic run(input logic [15:0] d0, input logic dc0, input logic [15:0] d1,
                     input bit hold, input int acc2, input int poke, input int n);
    int t;
    t = 0;
    while (!(v_sel ? if_b.req_ready : if_a.req_ready) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (t >= 200) begin n_fail++; $display("FAIL start_timeout: req_ready stayed 0, required 1"); end
    v_data = d0; v_dc = dc0; v_valid = 1'b1;
    @(posedge clk); #1; sample(0);
    if (hold) v_data = d1; else v_valid = 1'b0;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1; sample(e);
      if (hold && e == acc2) v_valid = 1'b0;
      if (!hold) begin
        v_valid = (e + 1 == poke);
        if (e + 1 == poke) v_data = 16'h00FF;
      end
    end
    v_valid = 1'b0;
  endtask

  function automatic int rises(input int lo, input int hi);
    int c = 0;
    for (int e = (lo < 1 ? 1 : lo); e <= hi; e++) if (s_sck[e] && !s_sck[e-1]) c++;
    return c;
  endfunction

  function automatic logic [15:0] rise_bits(input int lo, input int hi);
    logic [15:0] w = '0;
    for (int e = (lo < 1 ? 1 : lo); e <= hi; e++)
      if (s_sck[e] && !s_sck[e-1]) w = {w[14:0], s_mosi[e]};
    return w;
  endfunction

  function automatic int first_rise(input int lo, input int hi);
    for (int e = (lo < 1 ? 1 : lo); e <= hi; e++) if (s_sck[e] && !s_sck[e-1]) return e;
    return -1;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int e = lo; e <= hi; e++) if (s_done[e]) c++;
    return c;
  endfunction

  function automatic int count_cs_hi(input int lo, input int hi);
    int c = 0;
    for (int e = lo; e <= hi; e++) if (s_cs[e]) c++;
    return c;
  endfunction

  function automatic int count_dc_ne(input int lo, input int hi, input logic v);
    int c = 0;
    for (int e = lo; e <= hi; e++) if (s_dc[e] !== v) c++;
    return c;
  endfunction

  function automatic int count_rdy(input int lo, input int hi);
    int c = 0;
    for (int e = lo; e <= hi; e++) if (s_rdy[e]) c++;
    return c;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int e = lo; e <= hi; e++) if (s_busy[e]) c++;
    return c;
  endfunction

  task automatic test_reset();
    int nd, nc;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_sck !== 1'b0)  begin n_fail++; $display("FAIL rst_sck: got %b want 0", a_sck); end
    n_cmp++; if (a_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", a_cs_n); end
    n_cmp++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", a_mosi); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", a_done); end
    n_cmp++; if (if_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", if_a.req_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (if_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre: got %b want 0", if_a.req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (if_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", if_a.req_ready); end

    run(16'h00FF, 1'b1, 16'h0, 1'b0, 0, 0, 20);
    n_cmp++; if (a_sck !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL mid_shift_state: sck=%b busy=%b want 1 1", a_sck, a_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_sck !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_sck: got %b want 0", a_sck); end
    n_cmp++; if (a_cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cs_n: got %b want 1", a_cs_n); end
    n_cmp++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mosi: got %b want 0", a_mosi); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", a_done); end
    n_cmp++; if (if_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", if_a.req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (if_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready: got %b want 1", if_a.req_ready); end
    nd = 0; nc = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1;
      if (a_done) nd++;
      if (!a_cs_n) nc++;
    end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL abandon_done: got %0d pulses want 0", nd); end
    n_cmp++; if (nc !== 0) begin n_fail++; $display("FAIL abandon_cs: got %0d low clks want 0", nc); end
  endtask

  task automatic test_single_data();
    run(16'h00A5, 1'b1, 16'h0, 1'b0, 0, 0, 80);
    n_cmp++; if (rises(0, 80) !== 8) begin n_fail++; $display("FAIL a5_rises: got %0d want 8", rises(0, 80)); end
    n_cmp++; if (rise_bits(0, 80) !== 16'h00A5) begin n_fail++; $display("FAIL a5_bits: got %h want 00a5", rise_bits(0, 80)); end
    n_cmp++; if (first_rise(0, 80) !== 4) begin n_fail++; $display("FAIL a5_first_rise: got %0d want 4", first_rise(0, 80)); end
    n_cmp++; if (count_cs_hi(0, 71) !== 0) begin n_fail++; $display("FAIL a5_cs_low: got %0d high clks want 0", count_cs_hi(0, 71)); end
    n_cmp++; if (s_cs[72] !== 1'b1) begin n_fail++; $display("FAIL a5_cs_rise: got %b want 1", s_cs[72]); end
    n_cmp++; if (s_done[72] !== 1'b1) begin n_fail++; $display("FAIL a5_done_edge: got %b want 1", s_done[72]); end
    n_cmp++; if (count_done(0, 80) !== 1) begin n_fail++; $display("FAIL a5_done_count: got %0d want 1", count_done(0, 80)); end
    n_cmp++; if (count_dc_ne(0, 72, 1'b1) !== 0) begin n_fail++; $display("FAIL a5_dc: got %0d wrong clks want 0", count_dc_ne(0, 72, 1'b1)); end
  endtask

  task automatic test_command();
    run(16'h003C, 1'b0, 16'h0, 1'b0, 0, 0, 80);
    n_cmp++; if (rises(0, 80) !== 8) begin n_fail++; $display("FAIL 3c_rises: got %0d want 8", rises(0, 80)); end
    n_cmp++; if (rise_bits(0, 80) !== 16'h003C) begin n_fail++; $display("FAIL 3c_bits: got %h want 003c", rise_bits(0, 80)); end
    n_cmp++; if (count_dc_ne(0, 72, 1'b0) !== 0) begin n_fail++; $display("FAIL 3c_dc: got %0d wrong clks want 0", count_dc_ne(0, 72, 1'b0)); end
    n_cmp++; if (s_done[72] !== 1'b1) begin n_fail++; $display("FAIL 3c_done_edge: got %b want 1", s_done[72]); end
  endtask

  task automatic test_ignore_busy();
    run(16'h00A5, 1'b1, 16'h0, 1'b0, 0, 20, 80);
    n_cmp++; if (rise_bits(0, 80) !== 16'h00A5) begin n_fail++; $display("FAIL busy_bits: got %h want 00a5", rise_bits(0, 80)); end
    n_cmp++; if (rises(0, 80) !== 8) begin n_fail++; $display("FAIL busy_rises: got %0d want 8", rises(0, 80)); end
    n_cmp++; if (count_rdy(0, 70) !== 0) begin n_fail++; $display("FAIL busy_ready: got %0d ready clks want 0", count_rdy(0, 70)); end
    n_cmp++; if (s_rdy[73] !== 1'b1) begin n_fail++; $display("FAIL busy_ready_idle: got %b want 1", s_rdy[73]); end
    n_cmp++; if (count_busy(73, 80) !== 0) begin n_fail++; $display("FAIL busy_no_accept: got %0d busy clks want 0", count_busy(73, 80)); end
    n_cmp++; if (count_done(0, 80) !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", count_done(0, 80)); end
  endtask

  task automatic test_back_to_back();
    int acc2;
    acc2 = BURST ? 72 : 73;
    run(16'h0001, 1'b1, 16'h0080, 1'b1, acc2, 0, 150);
    n_cmp++; if (rise_bits(0, acc2) !== 16'h0001) begin n_fail++; $display("FAIL b2b_first_bits: got %h want 0001", rise_bits(0, acc2)); end
    n_cmp++; if (s_done[72] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", s_done[72]); end
    n_cmp++; if (s_busy[72] !== BURST) begin n_fail++; $display("FAIL b2b_busy72: got %b want %b", s_busy[72], BURST); end
    if (BURST) begin
      n_cmp++; if (count_cs_hi(0, 143) !== 0) begin n_fail++; $display("FAIL b2b_cs_held: got %0d high clks want 0", count_cs_hi(0, 143)); end
      n_cmp++; if (first_rise(73, 150) !== 76) begin n_fail++; $display("FAIL b2b_second_rise: got %0d want 76", first_rise(73, 150)); end
    end else begin
      n_cmp++; if (s_cs[72] !== 1'b1) begin n_fail++; $display("FAIL b2b_cs_gap: got %b want 1", s_cs[72]); end
      n_cmp++; if (s_cs[73] !== 1'b0 || s_busy[73] !== 1'b1) begin n_fail++; $display("FAIL b2b_accept73: cs_n=%b busy=%b want 0 1", s_cs[73], s_busy[73]); end
      n_cmp++; if (first_rise(73, 150) !== 77) begin n_fail++; $display("FAIL b2b_second_rise: got %0d want 77", first_rise(73, 150)); end
    end
    n_cmp++; if (rises(acc2, 150) !== 8) begin n_fail++; $display("FAIL b2b_second_rises: got %0d want 8", rises(acc2, 150)); end
    n_cmp++; if (rise_bits(acc2, 150) !== 16'h0080) begin n_fail++; $display("FAIL b2b_second_bits: got %h want 0080", rise_bits(acc2, 150)); end
    n_cmp++; if (s_done[acc2 + 72] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", s_done[acc2 + 72]); end
  endtask

  task automatic test_div1_size16();
    v_sel = 1'b1;
    run(16'h8001, 1'b1, 16'h0, 1'b0, 0, 0, 40);
    n_cmp++; if (rises(0, 40) !== 16) begin n_fail++; $display("FAIL w16_rises: got %0d want 16", rises(0, 40)); end
    n_cmp++; if (rise_bits(0, 40) !== 16'h8001) begin n_fail++; $display("FAIL w16_bits: got %h want 8001", rise_bits(0, 40)); end
    n_cmp++; if (first_rise(0, 40) !== 1) begin n_fail++; $display("FAIL w16_first_rise: got %0d want 1", first_rise(0, 40)); end
    n_cmp++; if (s_sck[2] !== 1'b0 || s_sck[3] !== 1'b1) begin n_fail++; $display("FAIL w16_period: sck2=%b sck3=%b want 0 1", s_sck[2], s_sck[3]); end
    n_cmp++; if (s_cs[33] !== 1'b0 || s_cs[34] !== 1'b1) begin n_fail++; $display("FAIL w16_cs: cs33=%b cs34=%b want 0 1", s_cs[33], s_cs[34]); end
    n_cmp++; if (s_done[34] !== 1'b1) begin n_fail++; $display("FAIL w16_done_edge: got %b want 1", s_done[34]); end
    n_cmp++; if (count_done(0, 40) !== 1) begin n_fail++; $display("FAIL w16_done_count: got %0d want 1", count_done(0, 40)); end
    v_sel = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    v_sel = 1'b0; v_valid = 1'b0; v_dc = 1'b0; v_data = '0;
    test_reset();
    test_single_data();
    test_command();
    test_ignore_busy();
    test_back_to_back();
    test_div1_size16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
